// File: rtl/lap_recorder.sv
// Lap-time capture buffer: DEPTH slots, stop-when-full or overwrite-oldest, indexed read port.
// Latency: capture on the lap rising-edge clock; rd_data/rd_valid registered one edge after rd_idx/state.
// Backpressure: none; laps arriving while full are dropped or overwrite the oldest, and set sticky ovf.
// Optional: define LAP_SPLIT_EN to add rd_split (per-lap split time stored alongside each lap).
module lap_recorder #(
  parameter  int DEPTH  = 5,
  parameter  int MW     = 7,
  parameter  int SW     = 7,
  parameter  int CW     = 7,
  localparam int DATA_W = MW + SW + CW,
  localparam int IDX_W  = $clog2(DEPTH),
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              sw_on,
  input  logic              lap,
  input  logic              clear,
  input  logic [MW-1:0]     min,
  input  logic [SW-1:0]     sec,
  input  logic [CW-1:0]     csec,
  input  logic              wrap_mode,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
`ifdef LAP_SPLIT_EN
  output logic [DATA_W-1:0] rd_split,
`endif
  output logic [CNT_W-1:0]  lap_cnt,
  output logic              full,
  output logic              ovf,
  output logic [DEPTH-1:0]  slot_free
);

  // Wide enough to hold head + count (both <= DEPTH) before the mod-DEPTH fold.
  localparam int SUM_W = IDX_W + 2;

  // Fold a sum of two in-range indices back into 0..DEPTH-1 (DEPTH need not be a power of two).
  function automatic logic [IDX_W-1:0] wrap_idx(input logic [SUM_W-1:0] s);
    logic [SUM_W-1:0] r;
    r = (s >= SUM_W'(DEPTH)) ? s - SUM_W'(DEPTH) : s;
    return IDX_W'(r);
  endfunction

`ifdef LAP_SPLIT_EN
  // Mixed-radix a - b: csec borrows at 100, sec at 60, minutes wrap modulo 2^MW.
  function automatic logic [DATA_W-1:0] split_sub(input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b);
    int dc;
    int ds;
    int dm;
    dc = int'(a[CW-1:0]) - int'(b[CW-1:0]);
    ds = int'(a[SW+CW-1:CW]) - int'(b[SW+CW-1:CW]);
    dm = int'(a[DATA_W-1:SW+CW]) - int'(b[DATA_W-1:SW+CW]);
    if (dc < 0) begin
      dc = dc + 100;
      ds = ds - 1;
    end
    if (ds < 0) begin
      ds = ds + 60;
      dm = dm - 1;
    end
    return {MW'(dm), SW'(ds), CW'(dc)};
  endfunction
`endif

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [IDX_W-1:0]  head_q, head_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic              lap_q;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;

  logic              lap_evt;
  logic              is_full;
  logic              cap_wr;
  logic              wipe;
  logic [IDX_W-1:0]  wr_slot;
  logic [IDX_W-1:0]  rd_slot;
  logic [DATA_W-1:0] cur_time;

`ifdef LAP_SPLIT_EN
  logic [DATA_W-1:0] split_mem_q [DEPTH];
  logic [DATA_W-1:0] prev_q;
  logic [DATA_W-1:0] rd_split_q, rd_split_d;
  logic [DATA_W-1:0] split_now;
`endif

  // Edge detect, write placement, occupancy/head/overflow next state and read-port lookup.
  always_comb begin
    cur_time   = {min, sec, csec};
    wipe       = !reset_n || (sw_on && clear);
    lap_evt    = lap & ~lap_q;
    is_full    = (cnt_q == CNT_W'(DEPTH));
    // When full, head + DEPTH folds to head, so one formula covers append and overwrite.
    wr_slot    = wrap_idx(SUM_W'(head_q) + SUM_W'(cnt_q));
    cap_wr     = lap_evt && (!is_full || wrap_mode);
    cnt_d      = cnt_q;
    head_d     = head_q;
    ovf_d      = ovf_q;
    if (lap_evt) begin
      if (!is_full) begin
        cnt_d = cnt_q + CNT_W'(1);
      end else begin
        ovf_d = 1'b1;
        if (wrap_mode) begin
          head_d = wrap_idx(SUM_W'(head_q) + SUM_W'(1));
        end
      end
    end
    rd_valid_d = (SUM_W'(rd_idx) < SUM_W'(cnt_q));
    rd_slot    = rd_valid_d ? wrap_idx(SUM_W'(head_q) + SUM_W'(rd_idx)) : '0;
    rd_data_d  = rd_valid_d ? mem_q[rd_slot] : '0;
`ifdef LAP_SPLIT_EN
    split_now  = split_sub(cur_time, prev_q);
    rd_split_d = rd_valid_d ? split_mem_q[rd_slot] : '0;
`endif
  end

  // All state: reset and clear wipe everything; otherwise capture laps and refresh the read port.
  always_ff @(posedge clk) begin
    // A lap held high through reset must not look like a fresh edge afterwards.
    lap_q <= reset_n ? lap : 1'b1;
    if (wipe) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      head_q     <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
`ifdef LAP_SPLIT_EN
      for (int i = 0; i < DEPTH; i++) begin
        split_mem_q[i] <= '0;
      end
      prev_q     <= '0;
      rd_split_q <= '0;
`endif
    end else begin
      head_q     <= head_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      if (cap_wr) begin
        mem_q[wr_slot] <= cur_time;
      end
`ifdef LAP_SPLIT_EN
      // The split reference advances on every lap event, even when the lap itself is dropped.
      if (lap_evt) begin
        prev_q <= cur_time;
      end
      if (cap_wr) begin
        split_mem_q[wr_slot] <= split_now;
      end
      rd_split_q <= rd_split_d;
`endif
    end
  end

  // Per-slot emptiness decode of the live count.
  always_comb begin
    slot_free = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slot_free[i] = (i >= int'(cnt_q));
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign lap_cnt  = cnt_q;
  assign full     = is_full;
  assign ovf      = ovf_q;
`ifdef LAP_SPLIT_EN
  assign rd_split = rd_split_q;
`endif

endmodule

// File: tb/tb_lap_recorder.sv
// Scoreboard bench for lap_recorder (DEPTH=5): directed laps, expected values queued per cycle,
// a negedge monitor pops and compares whatever is due in the current cycle.
module tb_lap_recorder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        sw_on;
  logic        lap;
  logic        clear;
  logic [6:0]  min;
  logic [6:0]  sec;
  logic [6:0]  csec;
  logic        wrap_mode;
  logic [2:0]  rd_idx;
  logic [20:0] rd_data;
  logic        rd_valid;
  logic [2:0]  lap_cnt;
  logic        full;
  logic        ovf;
  logic [4:0]  slot_free;
`ifdef LAP_SPLIT_EN
  logic [20:0] rd_split;
`endif

  always #5 clk = ~clk;

  lap_recorder dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .sw_on     (sw_on),
    .lap       (lap),
    .clear     (clear),
    .min       (min),
    .sec       (sec),
    .csec      (csec),
    .wrap_mode (wrap_mode),
    .rd_idx    (rd_idx),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
`ifdef LAP_SPLIT_EN
    .rd_split  (rd_split),
`endif
    .lap_cnt   (lap_cnt),
    .full      (full),
    .ovf       (ovf),
    .slot_free (slot_free)
  );

  typedef struct {
    int          cyc;
    int          id;
    logic [20:0] data;
    logic        vld;
    logic [2:0]  cnt;
    logic        full;
    logic        ovf;
    logic [4:0]  free;
    logic        chk_split;
    logic [20:0] split;
  } exp_t;

  exp_t sb_q[$];
  exp_t e_mon;
  int   cyc    = 0;
  int   id_n   = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [20:0] tm(input logic [6:0] m, input logic [6:0] s, input logic [6:0] c);
    return {m, s, c};
  endfunction

  task automatic cmp(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (check #%0d): got %h, expected %h", nm, id, act, exp);
    end
  endtask

  // Monitor: compare every expectation due this cycle; anything older was missed.
  always @(negedge clk) begin
    while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
      e_mon = sb_q.pop_front();
      if (e_mon.cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL missed (check #%0d): due cycle %0d, now %0d", e_mon.id, e_mon.cyc, cyc);
      end else begin
        cmp("rd_data",   e_mon.id, 32'(rd_data),   32'(e_mon.data));
        cmp("rd_valid",  e_mon.id, 32'(rd_valid),  32'(e_mon.vld));
        cmp("lap_cnt",   e_mon.id, 32'(lap_cnt),   32'(e_mon.cnt));
        cmp("full",      e_mon.id, 32'(full),      32'(e_mon.full));
        cmp("ovf",       e_mon.id, 32'(ovf),       32'(e_mon.ovf));
        cmp("slot_free", e_mon.id, 32'(slot_free), 32'(e_mon.free));
`ifdef LAP_SPLIT_EN
        if (e_mon.chk_split) cmp("rd_split", e_mon.id, 32'(rd_split), 32'(e_mon.split));
`endif
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [20:0] d, input logic v, input logic [2:0] c, input logic f,
                      input logic o, input logic [4:0] fr,
                      input logic cs = 1'b0, input logic [20:0] sp = '0);
    exp_t e;
    e.cyc = cyc; e.id = id_n; e.data = d; e.vld = v; e.cnt = c; e.full = f;
    e.ovf = o; e.free = fr; e.chk_split = cs; e.split = sp;
    id_n++;
    sb_q.push_back(e);
  endtask

  task automatic look(input logic [2:0] idx, input logic [20:0] d, input logic v, input logic [2:0] c,
                      input logic f, input logic o, input logic [4:0] fr,
                      input logic cs = 1'b0, input logic [20:0] sp = '0);
    rd_idx = idx;
    tick(1);
    push(d, v, c, f, o, fr, cs, sp);
  endtask

  task automatic do_lap(input logic [6:0] m, input logic [6:0] s, input logic [6:0] c);
    min = m; sec = s; csec = c;
    lap = 1'b1;
    tick(1);
    lap = 1'b0;
    tick(1);
  endtask

  task automatic do_clear();
    sw_on = 1'b1; clear = 1'b1;
    tick(1);
    clear = 1'b0; sw_on = 1'b0;
  endtask

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    reset_n = 1'b0; sw_on = 1'b0; lap = 1'b0; clear = 1'b0;
    min = '0; sec = '0; csec = '0; wrap_mode = 1'b0; rd_idx = '0;
    tick(2);
    push('0, 1'b0, 3'd0, 1'b0, 1'b0, 5'b11111);
    reset_n = 1'b1;
    tick(1);

    // Three laps, then read back by logical index.
    do_lap(7'd0, 7'd1, 7'd20);
    do_lap(7'd0, 7'd2, 7'd5);
    do_lap(7'd1, 7'd0, 7'd0);
    look(3'd2, tm(1, 0, 0),   1'b1, 3'd3, 1'b0, 1'b0, 5'b11000);
    look(3'd0, tm(0, 1, 20),  1'b1, 3'd3, 1'b0, 1'b0, 5'b11000);
    look(3'd3, '0,            1'b0, 3'd3, 1'b0, 1'b0, 5'b11000);

    // Clear ignored while stopwatch mode is off.
    sw_on = 1'b0; clear = 1'b1;
    tick(1);
    clear = 1'b0;
    look(3'd1, tm(0, 2, 5),   1'b1, 3'd3, 1'b0, 1'b0, 5'b11000);

    // Clear with a coincident lap edge: clear wins, lap lost, no ovf.
    min = 7'd3; sec = 7'd3; csec = 7'd3;
    sw_on = 1'b1; clear = 1'b1; lap = 1'b1;
    tick(1);
    clear = 1'b0; sw_on = 1'b0; lap = 1'b0;
    tick(1);
    look(3'd0, '0,            1'b0, 3'd0, 1'b0, 1'b0, 5'b11111);

    // Stop-when-full: sixth lap dropped.
    wrap_mode = 1'b0;
    for (int k = 1; k <= 6; k++) do_lap(7'd0, 7'(k), 7'd0);
    look(3'd4, tm(0, 5, 0),   1'b1, 3'd5, 1'b1, 1'b1, 5'b00000);
    look(3'd0, tm(0, 1, 0),   1'b1, 3'd5, 1'b1, 1'b1, 5'b00000);
    do_clear();
    look(3'd0, '0,            1'b0, 3'd0, 1'b0, 1'b0, 5'b11111);

    // Ring mode: seven laps overwrite the two oldest.
    wrap_mode = 1'b1;
    for (int k = 1; k <= 7; k++) do_lap(7'd0, 7'(k), 7'd0);
    look(3'd0, tm(0, 3, 0),   1'b1, 3'd5, 1'b1, 1'b1, 5'b00000);
    look(3'd4, tm(0, 7, 0),   1'b1, 3'd5, 1'b1, 1'b1, 5'b00000);
    look(3'd2, tm(0, 5, 0),   1'b1, 3'd5, 1'b1, 1'b1, 5'b00000);
    look(3'd7, '0,            1'b0, 3'd5, 1'b1, 1'b1, 5'b00000);

    // Mode switched back to drop: next lap leaves the ring untouched.
    wrap_mode = 1'b0;
    do_lap(7'd0, 7'd8, 7'd0);
    look(3'd4, tm(0, 7, 0),   1'b1, 3'd5, 1'b1, 1'b1, 5'b00000);
    look(3'd0, tm(0, 3, 0),   1'b1, 3'd5, 1'b1, 1'b1, 5'b00000);
    do_clear();

    // Lap held high through reset release: no capture.
    lap = 1'b1; reset_n = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(3);
    lap = 1'b0;
    tick(1);
    look(3'd0, '0,            1'b0, 3'd0, 1'b0, 1'b0, 5'b11111);

    // Long lap level: exactly one capture.
    min = 7'd0; sec = 7'd9; csec = 7'd9;
    lap = 1'b1;
    tick(10);
    lap = 1'b0;
    tick(1);
    look(3'd0, tm(0, 9, 9),   1'b1, 3'd1, 1'b0, 1'b0, 5'b11110);
    look(3'd1, '0,            1'b0, 3'd1, 1'b0, 1'b0, 5'b11110);

    // Read timing: status moves at the capture edge, rd_data one edge later.
    rd_idx = 3'd1;
    min = 7'd0; sec = 7'd10; csec = 7'd0;
    lap = 1'b1;
    tick(1);
    push('0, 1'b0, 3'd2, 1'b0, 1'b0, 5'b11100);
    lap = 1'b0;
    tick(1);
    push(tm(0, 10, 0), 1'b1, 3'd2, 1'b0, 1'b0, 5'b11100);

`ifdef LAP_SPLIT_EN
    do_clear();
    do_lap(7'd0, 7'd59, 7'd90);
    do_lap(7'd1, 7'd0,  7'd10);
    look(3'd1, tm(1, 0, 10),  1'b1, 3'd2, 1'b0, 1'b0, 5'b11100, 1'b1, tm(0, 0, 20));
    look(3'd0, tm(0, 59, 90), 1'b1, 3'd2, 1'b0, 1'b0, 5'b11100, 1'b1, tm(0, 59, 90));
`endif

    tick(2);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lap_recorder.md
Name: lap_recorder

Overview:
- Parametrised lap-time capture buffer for the stopwatch path; successor to the fixed 5-slot lap register bank.
- On each rising edge of the lap request, stores the current {min, sec, csec} time into a DEPTH-entry buffer.
- Offers stop-when-full or ring (overwrite-oldest) mode, occupancy/count/overflow status, and an indexed registered read port for the display mux.
- Sits between the stopwatch counter and the display/assignment logic.

Parameters:
- DEPTH, 5, number of lap slots (2..16).
- MW, 7, minute field width.
- SW, 7, second field width (values 0..59).
- CW, 7, centisecond field width (values 0..99).
- Derived, not overridable: DATA_W = MW+SW+CW; IDX_W = clog2(DEPTH); CNT_W = clog2(DEPTH+1).

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset_n  in  1  synchronous, active-low reset.
- sw_on  in  1  stopwatch mode active; gates clear.
- lap  in  1  lap request level, asynchronous to events; rising edge detected internally.
- clear  in  1  clear all laps; effective only when sw_on=1.
- min  in  MW  current minutes.
- sec  in  SW  current seconds.
- csec  in  CW  current centiseconds.
- wrap_mode  in  1  0 = drop laps when full; 1 = overwrite oldest.
- rd_idx  in  IDX_W  logical read index; 0 = oldest stored lap.
- rd_data  out  DATA_W  registered {min,sec,csec} of slot rd_idx.
- rd_valid  out  1  registered; 1 when rd_idx < lap_cnt.
- lap_cnt  out  CNT_W  number of stored laps, 0..DEPTH.
- full  out  1  lap_cnt == DEPTH.
- ovf  out  1  sticky; a lap was dropped or overwritten since the last clear/reset.
- slot_free  out  DEPTH  bit i = 1 when logical slot i is empty (i >= lap_cnt).

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - storage, rd_data, head pointer, lap_cnt, ovf and rd_valid go to 0; slot_free goes to all ones.
  - The lap edge register lap_q is set to 1, so a lap held high through reset is not captured.
  - Reset overrides clear and lap.
- Clear (sw_on=1 and clear=1): same effect as reset, except lap_q simply samples lap. Clear beats a lap edge in the same cycle; that lap is lost and does not set ovf.
- Lap edge: lap_evt = lap & ~lap_q; lap_q <= lap every cycle. Capture is independent of sw_on.
- On lap_evt with lap_cnt < DEPTH: write {min,sec,csec} to physical slot (head+lap_cnt) mod DEPTH, and increment lap_cnt, all at the same edge.
- On lap_evt when full:
  - wrap_mode=0: lap dropped, storage unchanged, ovf <= 1.
  - wrap_mode=1: overwrite physical slot head, head <= (head+1) mod DEPTH, lap_cnt stays DEPTH, ovf <= 1.
- Mode change: wrap_mode may change at any time and takes effect on the next lap_evt; it does not alter stored data.
- Read port:
  - Each edge, rd_data <= (rd_idx < lap_cnt) ? mem[(head+rd_idx) mod DEPTH] : 0, using pre-edge state. Logical-to-physical mapping is mod DEPTH; DEPTH need not be a power of two.
  - rd_valid is registered alongside rd_data.
  - Timing: a lap captured at edge t appears on rd_data after edge t+1; an rd_idx change shows after 1 edge.
  - rd_idx >= DEPTH gives rd_valid=0 and rd_data=0.
- Status: lap_cnt, full and slot_free are combinational decodes of registered state and update at the capture edge.

Optional Feature:
- Macro: LAP_SPLIT_EN.
- When defined:
  - Adds output rd_split (DATA_W), registered with rd_data: the split time of that lap, i.e. its capture time minus the previous lap-event time.
  - The previous lap-event time is stored in a register updated on every lap_evt, including dropped laps; it resets/clears to 0.
  - Subtraction is mixed-radix: csec borrows at 100, sec borrows at 60, min wraps modulo 2^MW.
  - Splits are computed at capture and stored in a parallel DEPTH array.
- When undefined: no rd_split port and no split storage or subtractor.

Test Plan:
- Reset, then 3 lap pulses at 00:01.20, 00:02.05, 01:00.00 -> lap_cnt=3, slot_free=5'b11000, rd_idx=2 gives rd_data={1,0,0}, rd_valid=1.
- wrap_mode=0, 6 laps (times 1..6 s) -> lap_cnt=5, full=1, ovf=1; rd_idx=4 reads 5 s, and the 6th lap is absent.
- wrap_mode=1, 7 laps (times 1..7 s) -> rd_idx=0 reads 3 s, rd_idx=4 reads 7 s, ovf=1, lap_cnt=5.
- clear=1 with sw_on=0 -> no change. clear=1 with sw_on=1, coincident with a lap edge -> lap_cnt=0, ovf=0, slot_free all ones, and the lap is lost.
- lap held high through deassertion of reset_n -> no capture. lap high for 10 cycles -> exactly one capture. rd_data is updated the edge after the capture edge.
- LAP_SPLIT_EN defined: laps at 00:59.90 then 01:00.10 -> rd_split for rd_idx=1 = {0,0,20}; the first lap's split = {0,59,90}.
